// File: rtl/fetch_prefetch_buffer_if.sv
// Bundles the redirect, instruction-memory and fetch-output signals of the prefetch buffer.
// master is the prefetch buffer itself; slave is the memory/fetch-stage side.
interface fetch_prefetch_buffer_if;
   logic        redirect;
   logic [63:0] redirect_pc;
   logic        mem_req;
   logic [63:0] mem_addr;
   logic        mem_gnt;
   logic        mem_resp_valid;
   logic [63:0] mem_resp_data;
   logic        mem_resp_error;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_pc;
   logic [7:0]  out_ibyte;
   logic [71:0] out_ibytes;
   logic [3:0]  out_len;
   logic        out_imem_error;

   modport master (
      input  redirect, redirect_pc, mem_gnt, mem_resp_valid, mem_resp_data,
             mem_resp_error, out_ready,
      output mem_req, mem_addr, out_valid, out_pc, out_ibyte, out_ibytes,
             out_len, out_imem_error
   );

   modport slave (
      output redirect, redirect_pc, mem_gnt, mem_resp_valid, mem_resp_data,
             mem_resp_error, out_ready,
      input  mem_req, mem_addr, out_valid, out_pc, out_ibyte, out_ibytes,
             out_len, out_imem_error
   );
endinterface

// File: rtl/fetch_prefetch_buffer.sv
// Instruction prefetch buffer: fetches 8-byte lines into a byte queue and presents
// one complete instruction (or a fetch fault) per handshake, flushing on redirect.
module fetch_prefetch_buffer #(
   parameter int BUF_BYTES = 24
) (
   input logic clock,
   input logic reset,
   fetch_prefetch_buffer_if.master bus
);

   localparam int CW = $clog2(BUF_BYTES + 1);
   localparam int IW = $clog2(BUF_BYTES);

   logic [7:0]    buf_q [BUF_BYTES];
   logic [7:0]    buf_d [BUF_BYTES];
   logic [CW-1:0] count_q, count_d;
   logic [63:0]   fetch_pc_q, fetch_pc_d;
   logic [63:0]   line_q, line_d;
   logic [2:0]    skip_q, skip_d;
   logic          outstanding_q, outstanding_d;
   logic          stale_q, stale_d;
   logic          err_q, err_d;
   logic          halted_q, halted_d;

   logic [3:0]    head_len;
   logic          normal_valid, err_valid, space_ok, req, grant, resp, xfer, append;
   logic [CW-1:0] pop_len, count_mid;
   logic [3:0]    append_len;
   int            pos;

   function automatic logic [3:0] decode_len(input logic [3:0] icode);
      case (icode)
         4'h0, 4'h1, 4'h9:       decode_len = 4'd1;
         4'h2, 4'h6, 4'hA, 4'hB: decode_len = 4'd2;
         4'h7, 4'h8:             decode_len = 4'd9;
         4'h3, 4'h4, 4'h5:       decode_len = 4'd10;
         default:                decode_len = 4'd1;
      endcase
   endfunction

   always_comb begin
      head_len     = decode_len(buf_q[0][7:4]);
      normal_valid = (count_q != '0) && (count_q >= CW'(head_len));
      err_valid    = err_q && !normal_valid;
      // Space for a whole line is reserved at issue so an append can never overflow.
      space_ok     = ({1'b0, count_q} + (CW+1)'(8)) <= (CW+1)'(BUF_BYTES);
      req          = !outstanding_q && space_ok && !err_q && !halted_q && !bus.redirect;
      grant        = req && bus.mem_gnt;
      resp         = outstanding_q && bus.mem_resp_valid;
      xfer         = normal_valid && bus.out_ready && !bus.redirect;
      append       = resp && !stale_q && !bus.mem_resp_error;
   end

   always_comb begin
      bus.mem_req        = req && !reset;
      bus.mem_addr       = reset ? 64'd0 : line_q;
      bus.out_valid      = !reset && (normal_valid || err_valid);
      bus.out_pc         = reset ? 64'd0 : fetch_pc_q;
      bus.out_ibyte      = reset ? 8'd0 : buf_q[0];
      bus.out_len        = reset ? 4'd0 : (err_valid ? 4'd1 : head_len);
      bus.out_imem_error = !reset && err_valid;
      bus.out_ibytes     = '0;
      for (int k = 1; k <= 9; k++) begin
         if (!reset) bus.out_ibytes[8*(k-1) +: 8] = buf_q[k];
      end
   end

   always_comb begin
      pop_len    = xfer ? CW'(head_len) : '0;
      count_mid  = count_q - pop_len;
      append_len = 4'd8 - {1'b0, skip_q};
      pos        = 0;
      for (int i = 0; i < BUF_BYTES; i++) begin
         if (i + int'(pop_len) < BUF_BYTES) buf_d[i] = buf_q[IW'(i + int'(pop_len))];
         else                               buf_d[i] = '0;
      end
      // Incoming bytes land directly behind whatever survives this cycle's pop.
      for (int j = 0; j < 8; j++) begin
         pos = int'(count_mid) + j - int'(skip_q);
         if (append && j >= int'(skip_q) && pos < BUF_BYTES)
            buf_d[IW'(pos)] = bus.mem_resp_data[8*j +: 8];
      end

      count_d       = count_mid + (append ? CW'(append_len) : '0);
      fetch_pc_d    = xfer ? fetch_pc_q + 64'(head_len) : fetch_pc_q;
      halted_d      = halted_q || (xfer && buf_q[0][7:4] == 4'h0);
      line_d        = grant ? line_q + 64'd8 : line_q;
      outstanding_d = grant ? 1'b1 : (resp ? 1'b0 : outstanding_q);
      stale_d       = resp ? 1'b0 : stale_q;
      err_d         = err_q || (resp && !stale_q && bus.mem_resp_error);
      skip_d        = append ? 3'd0 : skip_q;

      if (bus.redirect) begin
         count_d       = '0;
         fetch_pc_d    = bus.redirect_pc;
         line_d        = {bus.redirect_pc[63:3], 3'b000};
         skip_d        = bus.redirect_pc[2:0];
         err_d         = 1'b0;
         halted_d      = 1'b0;
         // A line still in flight belongs to the old stream and must be dropped on arrival.
         outstanding_d = outstanding_q && !bus.mem_resp_valid;
         stale_d       = outstanding_q && !bus.mem_resp_valid;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < BUF_BYTES; i++) buf_q[i] <= '0;
         count_q       <= '0;
         fetch_pc_q    <= '0;
         line_q        <= '0;
         skip_q        <= '0;
         outstanding_q <= 1'b0;
         stale_q       <= 1'b0;
         err_q         <= 1'b0;
         halted_q      <= 1'b0;
      end else begin
         buf_q         <= buf_d;
         count_q       <= count_d;
         fetch_pc_q    <= fetch_pc_d;
         line_q        <= line_d;
         skip_q        <= skip_d;
         outstanding_q <= outstanding_d;
         stale_q       <= stale_d;
         err_q         <= err_d;
         halted_q      <= halted_d;
      end
   end

endmodule

// File: tb/tb_fetch_prefetch_buffer.sv
// Directed bench for fetch_prefetch_buffer: a byte-addressed memory image answers requests,
// and each expected instruction is queued and compared when the DUT hands it over.
module tb_fetch_prefetch_buffer;

   logic clock = 1'b0;
   logic reset;

   fetch_prefetch_buffer_if bus ();

   fetch_prefetch_buffer #(.BUF_BYTES(24)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [63:0] pc;
      logic [3:0]  len;
   } exp_t;

   int          checks = 0;
   int          failures = 0;
   logic [7:0]  mem [logic [63:0]];
   exp_t        exp_q [$];
   logic [63:0] gnt_log [$];

   bit          pend_valid = 0;
   logic [63:0] pend_addr = '0;
   int          pend_delay = 0;
   int          resp_delay = 0;
   bit          gnt_en = 0;
   bit          err_en = 0;
   logic [63:0] err_addr = '0;
   bit          rst_drv = 1;
   bit          ready_drv = 0;
   bit          redir_drv = 0;
   logic [63:0] redir_pc_drv = '0;
   bit          mon_en = 0;

   // Unwritten memory reads as nops so nothing halts by accident.
   function automatic logic [7:0] mem_byte(input logic [63:0] a);
      if (mem.exists(a)) return mem[a];
      return 8'h10;
   endfunction

   function automatic logic [63:0] mem_word(input logic [63:0] a);
      logic [63:0] w;
      w = '0;
      for (int i = 0; i < 8; i++) w[8*i +: 8] = mem_byte(a + 64'(i));
      return w;
   endfunction

   function automatic logic [63:0] gnt_at(input int i);
      if (i < gnt_log.size()) return gnt_log[i];
      return '1;
   endfunction

   task automatic checkOutput(input string tag, input logic [71:0] got, input logic [71:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic monitor();
      exp_t        e;
      logic [71:0] eb;
      logic [71:0] m;
      checks++;
      assert (exp_q.size() > 0) else begin
         failures++;
         $error("[TB] FAIL xfer_unexpected: observed pc=%0h expected=no transfer", bus.out_pc);
      end
      if (exp_q.size() > 0) begin
         e  = exp_q.pop_front();
         eb = '0;
         m  = '0;
         for (int k = 1; k < int'(e.len); k++) begin
            eb[8*(k-1) +: 8] = mem_byte(e.pc + 64'(k));
            m[8*(k-1) +: 8]  = 8'hFF;
         end
         checkOutput("out_pc", 72'(bus.out_pc), 72'(e.pc));
         checkOutput("out_len", 72'(bus.out_len), 72'(e.len));
         checkOutput("out_ibyte", 72'(bus.out_ibyte), 72'(mem_byte(e.pc)));
         checkOutput("out_ibytes", bus.out_ibytes & m, eb);
         checkOutput("out_imem_error", 72'(bus.out_imem_error), 72'(0));
         if (mem_byte(e.pc) == 8'h00) gnt_log.delete();
      end
   endtask

   // One clock cycle: drive inputs at the falling edge, then play memory and scoreboard.
   task automatic applyStimulus();
      @(negedge clock);
      reset              = rst_drv;
      bus.redirect       = redir_drv;
      bus.redirect_pc    = redir_pc_drv;
      bus.out_ready      = ready_drv;
      bus.mem_resp_valid = 1'b0;
      bus.mem_resp_error = 1'b0;
      bus.mem_resp_data  = '0;
      if (pend_valid) begin
         if (pend_delay == 0) begin
            bus.mem_resp_valid = 1'b1;
            bus.mem_resp_data  = mem_word(pend_addr);
            bus.mem_resp_error = err_en && (pend_addr == err_addr);
            pend_valid         = 0;
         end else begin
            pend_delay--;
         end
      end
      bus.mem_gnt = gnt_en;
      #1;
      if (bus.mem_req && bus.mem_gnt) begin
         pend_valid = 1;
         pend_addr  = bus.mem_addr;
         pend_delay = resp_delay;
         gnt_log.push_back(bus.mem_addr);
      end
      if (mon_en && bus.out_valid && bus.out_ready && !bus.redirect) monitor();
   endtask

   task automatic do_redirect(input logic [63:0] pc);
      redir_drv    = 1;
      redir_pc_drv = pc;
      gnt_log.delete();
      applyStimulus();
      redir_drv    = 0;
   endtask

   task automatic expect_run(input logic [63:0] pc, input int n);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         e.pc  = pc + 64'(i);
         e.len = 4'd1;
         exp_q.push_back(e);
      end
   endtask

   task automatic expect_instr(input logic [63:0] pc, input logic [3:0] len);
      exp_t e;
      e.pc  = pc;
      e.len = len;
      exp_q.push_back(e);
   endtask

   task automatic drain(input string tag, input int max_cycles);
      ready_drv = 1;
      for (int i = 0; i < max_cycles && exp_q.size() > 0; i++) applyStimulus();
      ready_drv = 0;
      checkOutput({tag, "_drained"}, 72'(exp_q.size()), 72'(0));
      exp_q.delete();
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset              = 1'b1;
      bus.redirect       = 1'b0;
      bus.redirect_pc    = '0;
      bus.mem_gnt        = 1'b0;
      bus.mem_resp_valid = 1'b0;
      bus.mem_resp_data  = '0;
      bus.mem_resp_error = 1'b0;
      bus.out_ready      = 1'b0;

      mem[64'h0] = 8'h30;
      mem[64'h1] = 8'hF4;
      mem[64'h2] = 8'h10;
      for (int i = 3; i <= 9; i++) mem[64'(i)] = 8'h00;
      mem[64'h30D] = 8'h60;
      mem[64'h30E] = 8'h23;
      mem[64'h30F] = 8'h70;
      mem[64'h310] = 8'h40;
      mem[64'h311] = 8'h03;
      for (int i = 'h312; i <= 'h317; i++) mem[64'(i)] = 8'h00;
      for (int i = 'h400; i <= 'h407; i++) mem[64'(i)] = 8'hFF;
      mem[64'h606] = 8'h30;
      mem[64'h607] = 8'hF2;
      mem[64'h704] = 8'h00;

      // Reset: every output low, then the first request appears once reset drops.
      applyStimulus();
      checkOutput("rst_mem_req", 72'(bus.mem_req), 72'(0));
      checkOutput("rst_out_valid", 72'(bus.out_valid), 72'(0));
      checkOutput("rst_mem_addr", 72'(bus.mem_addr), 72'(0));
      checkOutput("rst_out_pc", 72'(bus.out_pc), 72'(0));
      rst_drv = 0;
      applyStimulus();
      checkOutput("post_rst_mem_req", 72'(bus.mem_req), 72'(1));
      checkOutput("post_rst_mem_addr", 72'(bus.mem_addr), 72'(0));
      checkOutput("post_rst_out_valid", 72'(bus.out_valid), 72'(0));
      gnt_en = 1;
      mon_en = 1;

      // irmovq at 0 followed by a stream of nops.
      do_redirect(64'h0);
      applyStimulus();
      checkOutput("redir0_out_valid", 72'(bus.out_valid), 72'(0));
      expect_instr(64'h0, 4'd10);
      expect_run(64'hA, 10);
      drain("irmovq_nops", 80);

      // With nobody consuming, fetching stops once three lines fill the queue.
      do_redirect(64'h200);
      repeat (12) applyStimulus();
      checkOutput("fill_grants", 72'(gnt_log.size()), 72'(3));
      checkOutput("fill_last_line", 72'(gnt_at(2)), 72'(64'h210));
      checkOutput("fill_mem_req", 72'(bus.mem_req), 72'(0));
      checkOutput("fill_out_valid", 72'(bus.out_valid), 72'(1));
      checkOutput("fill_out_pc", 72'(bus.out_pc), 72'(64'h200));

      // Misaligned redirect; the jXX straddles into the next line.
      resp_delay = 2;
      do_redirect(64'h30D);
      expect_instr(64'h30D, 4'd2);
      expect_instr(64'h30F, 4'd9);
      drain("jxx_straddle", 60);
      resp_delay = 0;

      // Redirect while a request is in flight; its 0xFF data must never surface.
      resp_delay = 3;
      do_redirect(64'h400);
      for (int i = 0; i < 20 && gnt_log.size() == 0; i++) applyStimulus();
      checkOutput("stale_first_gnt", 72'(gnt_at(0)), 72'(64'h400));
      do_redirect(64'h505);
      resp_delay = 0;
      applyStimulus();
      checkOutput("stale_out_valid", 72'(bus.out_valid), 72'(0));
      expect_run(64'h505, 6);
      drain("stale_drop", 60);
      checkOutput("stale_new_gnt", 72'(gnt_at(0)), 72'(64'h500));

      // Fetch fault on the second half of a 10-byte instruction.
      mon_en   = 0;
      err_en   = 1;
      err_addr = 64'h608;
      do_redirect(64'h606);
      ready_drv = 1;
      applyStimulus();
      for (int i = 0; i < 30 && !bus.out_valid; i++) applyStimulus();
      checkOutput("err_out_valid", 72'(bus.out_valid), 72'(1));
      checkOutput("err_imem_error", 72'(bus.out_imem_error), 72'(1));
      checkOutput("err_out_len", 72'(bus.out_len), 72'(1));
      checkOutput("err_out_pc", 72'(bus.out_pc), 72'(64'h606));
      checkOutput("err_mem_req", 72'(bus.mem_req), 72'(0));
      repeat (3) applyStimulus();
      checkOutput("err_hold_valid", 72'(bus.out_valid), 72'(1));
      checkOutput("err_hold_imem_error", 72'(bus.out_imem_error), 72'(1));
      checkOutput("err_hold_pc", 72'(bus.out_pc), 72'(64'h606));
      checkOutput("err_hold_mem_req", 72'(bus.mem_req), 72'(0));
      ready_drv = 0;
      err_en    = 0;

      // Halt at 0x704: queued nops still come out but no further lines are fetched.
      do_redirect(64'h700);
      applyStimulus();
      checkOutput("halt_redir_valid", 72'(bus.out_valid), 72'(0));
      checkOutput("halt_redir_imem_error", 72'(bus.out_imem_error), 72'(0));
      mon_en = 1;
      expect_run(64'h700, 4);
      expect_instr(64'h704, 4'd1);
      expect_run(64'h705, 8);
      drain("halt", 80);
      repeat (6) applyStimulus();
      checkOutput("halt_no_gnt", 72'(gnt_log.size()), 72'(0));
      checkOutput("halt_mem_req", 72'(bus.mem_req), 72'(0));
      checkOutput("halt_queued_valid", 72'(bus.out_valid), 72'(1));
      checkOutput("halt_queued_pc", 72'(bus.out_pc), 72'(64'h70D));
      do_redirect(64'h800);
      expect_run(64'h800, 2);
      drain("halt_resume", 40);
      checkOutput("resume_gnt", 72'(gnt_at(0)), 72'(64'h800));

      // Line address wraps past the top of the address space.
      do_redirect(64'hFFFF_FFFF_FFFF_FFF8);
      expect_run(64'hFFFF_FFFF_FFFF_FFF8, 8);
      drain("wrap", 60);
      checkOutput("wrap_gnt0", 72'(gnt_at(0)), 72'(64'hFFFF_FFFF_FFFF_FFF8));
      checkOutput("wrap_gnt1", 72'(gnt_at(1)), 72'(64'h0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
